// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
// Sequential converter from a four-digit packed-BCD number (0..9999) to a
// 14-bit unsigned binary value. It runs one digit per clock using a
// multiply-by-ten-and-add accumulator, so a valid request completes four
// edges after it is accepted.
//
// A request with any digit above 9 is rejected on the acceptance edge itself.
// In that case bin_out is cleared, error_o is set, and done_o pulses for
// one cycle.
//
// Ports
//   clk            rising-edge clock for all state
//   rst_n          asynchronous active-low reset
//   start_i        conversion request, sampled only while idle
//   bcd_thousands  most significant BCD digit
//   bcd_hundreds   BCD digit
//   bcd_tens       BCD digit
//   bcd_ones       least significant BCD digit
//   busy_o         high while a conversion is in progress
//   done_o         one-cycle pulse when a result or an error is available
//   bin_out        registered binary result, held between done_o pulses
//   error_o        registered flag: the last accepted request had a bad digit
// ---------------------------------------------------------------------------
module bcd_to_bin (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [3:0]  bcd_thousands,
   input  logic [3:0]  bcd_hundreds,
   input  logic [3:0]  bcd_tens,
   input  logic [3:0]  bcd_ones,
   output logic        busy_o,
   output logic        done_o,
   output logic [13:0] bin_out,
   output logic        error_o
);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [3:0]  dig_th;
   logic [3:0]  dig_hu;
   logic [3:0]  dig_te;
   logic [3:0]  dig_on;
   logic [13:0] acc;
   logic [1:0]  cnt;

   logic        accept;
   logic        bad_digit;
   logic        last_step;
   logic [3:0]  cur_digit;

   // acc*10 + d using shifts. The largest result is 9999, which fits in
   // 14 bits, so no wrap handling is needed.
   function automatic logic [13:0] mac10(input logic [13:0] a, input logic [3:0] d);
      return (a << 3) + (a << 1) + {10'd0, d};
   endfunction

   always_comb begin
      bad_digit = (bcd_thousands > 4'd9) || (bcd_hundreds > 4'd9) ||
                  (bcd_tens > 4'd9)      || (bcd_ones > 4'd9);
      accept    = (state == IDLE) && start_i;
      last_step = (state == CONV) && (cnt == 2'd3);
      unique case (cnt)
         2'd0:    cur_digit = dig_th;
         2'd1:    cur_digit = dig_hu;
         2'd2:    cur_digit = dig_te;
         default: cur_digit = dig_on;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic. A rejected request never leaves IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i && !bad_digit) state_nxt = CONV;
         CONV:    if (cnt == 2'd3)           state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o = (state == CONV);

   // Digit capture, accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_th  <= 4'd0;
         dig_hu  <= 4'd0;
         dig_te  <= 4'd0;
         dig_on  <= 4'd0;
         acc     <= 14'd0;
         cnt     <= 2'd0;
         done_o  <= 1'b0;
         bin_out <= 14'd0;
         error_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (accept) begin
            dig_th <= bcd_thousands;
            dig_hu <= bcd_hundreds;
            dig_te <= bcd_tens;
            dig_on <= bcd_ones;
            acc    <= 14'd0;
            cnt    <= 2'd0;
            if (bad_digit) begin
               bin_out <= 14'd0;
               error_o <= 1'b1;
               done_o  <= 1'b1;
            end else begin
               error_o <= 1'b0;
            end
         end else if (state == CONV) begin
            acc <= mac10(acc, cur_digit);
            cnt <= cnt + 2'd1;
            // The fourth step publishes its sum directly, so the result
            // appears on the same edge as done_o.
            if (last_step) begin
               bin_out <= mac10(acc, cur_digit);
               done_o  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
// Bench for bcd_to_bin. Each request pushes its decimal reference result
// ({error, value}) onto a queue. A monitor pops one entry for every done_o
// pulse. Each scenario task also checks latency, busy and hold behaviour
// inline.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [3:0]  bcd_thousands;
   logic [3:0]  bcd_hundreds;
   logic [3:0]  bcd_tens;
   logic [3:0]  bcd_ones;
   logic        busy_o;
   logic        done_o;
   logic [13:0] bin_out;
   logic        error_o;

   int          n_checks;
   int          n_fail;
   logic [14:0] sb[$];

   bcd_to_bin dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .bcd_thousands (bcd_thousands),
      .bcd_hundreds  (bcd_hundreds),
      .bcd_tens      (bcd_tens),
      .bcd_ones      (bcd_ones),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .bin_out       (bin_out),
      .error_o       (error_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard monitor: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      logic [14:0] exp_v;
      if (rst_n) begin
         n_checks++;
         if (busy_o && done_o) begin
            n_fail++;
            $display("FAIL busy_done_overlap: busy_o=%0b done_o=%0b required not both 1", busy_o, done_o);
         end
         if (done_o) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done: bin_out=%0d error_o=%0b with no request pending", bin_out, error_o);
            end else begin
               exp_v = sb.pop_front();
               if ({error_o, bin_out} !== exp_v) begin
                  n_fail++;
                  $display("FAIL result: got err=%0b bin=%0d, required err=%0b bin=%0d",
                           error_o, bin_out, exp_v[14], exp_v[13:0]);
               end
            end
         end
      end
   end

   // Decimal reference: the value if all digits are legal, otherwise an error.
   function automatic logic [14:0] model(input int d3, input int d2, input int d1, input int d0);
      int v;
      if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return {1'b1, 14'd0};
      v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
      return {1'b0, 14'(v)};
   endfunction

   // Call at a falling edge. Drives one request, then scrambles the digits
   // after acceptance. Returns how many falling edges after the request
   // done_o appeared, or -1 on timeout, and how many of them had busy_o high.
   task automatic run_one(input int d3, input int d2, input int d1, input int d0,
                          output int lat, output int busy_cnt);
      sb.push_back(model(d3, d2, d1, d0));
      start_i       = 1'b1;
      bcd_thousands = 4'(d3);
      bcd_hundreds  = 4'(d2);
      bcd_tens      = 4'(d1);
      bcd_ones      = 4'(d0);
      lat      = -1;
      busy_cnt = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start_i       = 1'b0;
            bcd_thousands = 4'($urandom_range(0, 15));
            bcd_hundreds  = 4'($urandom_range(0, 15));
            bcd_tens      = 4'($urandom_range(0, 15));
            bcd_ones      = 4'($urandom_range(0, 15));
         end
         if (busy_o) busy_cnt++;
         if (done_o) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n         = 1'b1;
      start_i       = 1'b1;
      bcd_thousands = 4'd9;
      bcd_hundreds  = 4'd9;
      bcd_tens      = 4'd9;
      bcd_ones      = 4'd9;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy_o, done_o, error_o, bin_out} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b bin=%0d, required all 0",
                  busy_o, done_o, error_o, bin_out);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_roundtrip;
      int vals[11] = '{0, 5, 10, 99, 123, 255, 512, 999, 1023, 2047, 9999};
      int lat;
      int bc;
      int v;
      for (int i = 0; i < 11; i++) begin
         v = vals[i];
         @(negedge clk);
         run_one(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10, lat, bc);
         n_checks++;
         if (lat !== 5 || bc !== 4) begin
            n_fail++;
            $display("FAIL latency_%0d: done after %0d edges busy %0d cycles, required 5 and 4", v, lat, bc);
         end
         @(negedge clk);
         n_checks++;
         if (done_o !== 1'b0 || bin_out !== 14'(v) || error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: done=%0b bin=%0d err=%0b, required 0 %0d 0", v, done_o, bin_out, error_o, v);
         end
      end
   endtask

   task automatic test_bad_digit;
      int lat;
      int bc;
      @(negedge clk);
      run_one(1, 2, 10, 4, lat, bc);
      n_checks++;
      if (lat !== 1 || bc !== 0) begin
         n_fail++;
         $display("FAIL bad_digit_latency: done after %0d edges busy %0d, required 1 and 0", lat, bc);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b1 || bin_out !== 14'd0) begin
            n_fail++;
            $display("FAIL bad_digit_hold: busy=%0b done=%0b err=%0b bin=%0d, required 0 0 1 0",
                     busy_o, done_o, error_o, bin_out);
         end
      end
      // A following legal request must clear the error flag.
      @(negedge clk);
      run_one(0, 0, 0, 7, lat, bc);
      n_checks++;
      if (lat !== 5 || error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL error_clear: lat=%0d err=%0b, required 5 and 0", lat, error_o);
      end
   endtask

   task automatic test_back_to_back;
      int first;
      int second;
      first  = -1;
      second = -1;
      @(negedge clk);
      sb.push_back(model(4, 3, 2, 1));
      sb.push_back(model(8, 8, 8, 8));
      start_i       = 1'b1;
      bcd_thousands = 4'd4;
      bcd_hundreds  = 4'd3;
      bcd_tens      = 4'd2;
      bcd_ones      = 4'd1;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bcd_thousands = 4'd8;
            bcd_hundreds  = 4'd8;
            bcd_tens      = 4'd8;
            bcd_ones      = 4'd8;
         end
         if (n == 6) start_i = 1'b0;
         if (done_o) begin
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
      end
      n_checks++;
      if (first !== 5 || second !== 10) begin
         n_fail++;
         $display("FAIL back_to_back: done at edges %0d and %0d, required 5 and 10", first, second);
      end
   endtask

   task automatic test_reset_abort;
      int lat;
      int bc;
      int dones;
      @(negedge clk);
      start_i       = 1'b1;
      bcd_thousands = 4'd5;
      bcd_hundreds  = 4'd6;
      bcd_tens      = 4'd7;
      bcd_ones      = 4'd8;
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy_o, done_o, error_o, bin_out} !== 17'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: busy=%0b done=%0b err=%0b bin=%0d, required all 0",
                  busy_o, done_o, error_o, bin_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_one(0, 0, 4, 2, lat, bc);
      n_checks++;
      if (lat !== 5 || bin_out !== 14'd42) begin
         n_fail++;
         $display("FAIL after_abort: lat=%0d bin=%0d, required 5 and 42", lat, bin_out);
      end
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL stray_done: %0d extra done pulses, required 0", dones);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_roundtrip();
      test_bad_digit();
      test_back_to_back();
      test_reset_abort();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
